// File: rtl/gate_identifier_if.sv
// Handshake and result bundle between a gate_identifier and the block driving it.
// The master side issues start and returns the gate response; the slave side is the sweeper.
interface gate_identifier_if;
   logic       start;
   logic       resp;
   logic       stim_A;
   logic       stim_B;
   logic       busy;
   logic       done;
   logic [3:0] truth_table;
   logic [2:0] gate_code;
   logic       valid_gate;

   modport master (
      output start, resp,
      input  stim_A, stim_B, busy, done, truth_table, gate_code, valid_gate
   );

   modport slave (
      input  start, resp,
      output stim_A, stim_B, busy, done, truth_table, gate_code, valid_gate
   );
endinterface

// File: rtl/gate_identifier.sv
// Sweeps all four {A,B} vectors through a two-input gate, samples each response after a
// programmable settle time, and decodes the resulting truth table into a gate code.
module gate_identifier #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic              clk,
   input logic              rst_n,
   gate_identifier_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] stim_q, stim_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] shadow_q, shadow_d;
   logic [3:0] tt_q, tt_d;
   logic [2:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [3:0] final_tt;

   function automatic logic [2:0] decode(input logic [3:0] tt);
      case (tt)
         4'b1000: decode = 3'd0;
         4'b1110: decode = 3'd1;
         4'b0011: decode = 3'd2;
         4'b0111: decode = 3'd3;
         4'b0001: decode = 3'd4;
         4'b0110: decode = 3'd5;
         4'b1001: decode = 3'd6;
         default: decode = 3'd7;
      endcase
   endfunction

   // The last vector's response bypasses the shadow so results appear with the done pulse.
   assign final_tt = {bus.resp, shadow_q[2:0]};

   always_comb begin
      // NOTE: every _d gets a default from its _q first, so no path leaves one unassigned
      // and no latch is inferred; combinational logic uses blocking assignments.
      state_d  = state_q;
      idx_d    = idx_q;
      stim_d   = stim_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      tt_d     = tt_q;
      code_d   = code_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               stim_d  = 2'b00;
               idx_d   = 2'd0;
               cnt_d   = 8'd0;
               busy_d  = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_LAST) state_d = SAMPLE;
            else                   cnt_d   = cnt_q + 8'd1;
         end
         SAMPLE: begin
            shadow_d[idx_q] = bus.resp;
            if (idx_q == 2'd3) begin
               tt_d    = final_tt;
               code_d  = decode(final_tt);
               valid_d = (decode(final_tt) != 3'd7);
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               stim_d  = idx_q + 2'd1;
               cnt_d   = 8'd0;
               state_d = SETTLE;
            end
         end
         DONE: begin
            stim_d  = 2'b00;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         stim_q   <= 2'b00;
         cnt_q    <= 8'd0;
         shadow_q <= 4'b0000;
         tt_q     <= 4'b0000;
         code_q   <= 3'd7;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         stim_q   <= stim_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         tt_q     <= tt_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.stim_A      = stim_q[1];
   assign bus.stim_B      = stim_q[0];
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.truth_table = tt_q;
   assign bus.gate_code   = code_q;
   assign bus.valid_gate  = valid_q;

endmodule

// File: doc/gate_identifier.md
# gate_identifier

Sequential truth-table sweeper that sits at the consuming end of a two-input logic gate bank. On command it drives all four input combinations onto a gate under test, waits a programmable settle time, samples the single-bit response for each vector, and decodes the 4-bit truth table into a gate code. Used as on-chip self-test and gate-selection check for the building-block library.

## Interface
- SETTLE_CYCLES, default 2: cycles `stim_A`/`stim_B` are held before the response is sampled; legal range 1..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; sampled on rising edge; accepted only in IDLE.
- resp  input  1  response of the gate under test.
- stim_A  output  1  gate input A stimulus, registered.
- stim_B  output  1  gate input B stimulus, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when results update.
- truth_table  output  4  bit i = response for {A,B} = i; bit0 is A=0,B=0; bit3 is A=1,B=1.
- gate_code  output  3  0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 unrecognised.
- valid_gate  output  1  high when gate_code != 7.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: if start=1 then stim <= vector 0 ({A,B}=00), idx <= 0, cnt <= 0, go to SETTLE.
  - SETTLE: if cnt == SETTLE_CYCLES-1 go to SAMPLE, else cnt++.
  - SAMPLE:
    - Capture shadow[idx] <= resp.
    - If idx==3, go to DONE.
    - Else idx++, stim <= next vector, cnt <= 0, go to SETTLE.
  - DONE: truth_table <= shadow, with the final bit taken from the SAMPLE capture. Update gate_code and valid_gate from the same value. Pulse done. Return to IDLE.
- Vector order: 00, 01, 10, 11 ({stim_A, stim_B} = idx). `idx` is a 2-bit counter.
- Decode of truth_table:
  - 1000 → AND; 1110 → OR; 0011 → NOT(A); 0111 → NAND.
  - 0001 → NOR; 0110 → XOR; 1001 → XNOR.
  - Anything else (constants, pass-through, NOT(B), ...) → 7, valid_gate=0.
- truth_table, gate_code and valid_gate hold the last completed result until the next DONE. A new sweep does not clear them.
- start while busy (including in DONE) is ignored. It is not queued.
- stim_A and stim_B return to 0 on entering IDLE.

## Timing
- Reset values (async, immediate):
  - stim_A=0, stim_B=0, busy=0, done=0.
  - truth_table=0000, gate_code=7, valid_gate=0.
  - Internal state IDLE; idx, cnt and shadow all 0.
- Let edge 0 be the rising edge that samples start=1 in IDLE.
  - busy is high from edge 0.
  - Vector k is driven from edge k·(S+1), where S = SETTLE_CYCLES.
  - Vector k is sampled at edge (k+1)·(S+1). Each vector is stable for S+1 cycles before its sample.
  - done is high for exactly one cycle, between edges 4(S+1) and 4(S+1)+1. Results are valid in that same cycle.
  - busy drops at edge 4(S+1)+1.
- Total sweep length: 4(S+1)+1 cycles. With S=2 this is 13; done is high after edge 12.
- start asserted in the cycle busy falls is accepted at that edge. This gives back-to-back sweeps with one IDLE cycle.
- Reset mid-sweep: abort immediately to reset values. No done pulse. Prior results are lost (reset values apply).
- resp is sampled only in SAMPLE. resp glitches in SETTLE have no effect.

## Test plan
- AND gate model on resp (resp = stim_A & stim_B), S=2, single start pulse:
  - Stimulus sequence 00,01,10,11, each held 3 cycles.
  - done pulses once at cycle 12.
  - truth_table=1000, gate_code=0, valid_gate=1.
  - busy high for 13 cycles.
- Sweep each of OR, NOT(A), NAND, NOR, XOR, XNOR models: gate_code=1..6 respectively, with the truth tables listed above.
- resp tied to 1:
  - truth_table=1111, gate_code=7, valid_gate=0.
  - Then run an XOR sweep: results become 0110/5. Outputs hold the old value until the new done.
- start held high continuously for 40 cycles, S=2:
  - Exactly three sweeps.
  - done pulses at cycles 12, 26 and 40, with one IDLE cycle between sweeps.
  - start during busy is ignored.
- rst_n pulled low at cycle 7 of an AND sweep:
  - All outputs take reset values asynchronously; no done pulse.
  - After release, a new start completes normally with 1000/0.
- S=1, and resp toggled during every SETTLE cycle (forced to the correct XNOR value only in SAMPLE):
  - Result 1001/6.
  - done pulses at cycle 8.
